pixel_feeder: RTL and testbench

- Read-side counterpart of the line and pixel writers.
- Fetches the active frame buffer from DDR through the shared address FIFO (af) and the read-data FIFO (rdf).
- Unpacks 128-bit beats into 24-bit pixels, buffers them, and streams them in raster order to the video output with a valid/ready handshake.
- Sits between the memory-interface FIFO arbiter and the display timing block.

---
 rtl/pixel_feeder.sv | 127 ++++++++++++
 tb/tb_pixel_feeder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_feeder.sv
// rtl/pixel_feeder.sv - frame buffer reader: DDR bursts in, raster pixels out (option: PIXEL_FEEDER_UNDERFLOW_COUNT_EN)
// Optional underflow counter port is present only when PIXEL_FEEDER_UNDERFLOW_COUNT_EN is defined.
module pixel_feeder #(
   parameter int H_PIXELS  = 800,
   parameter int V_PIXELS  = 600,
   parameter int BUF_DEPTH = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic [31:0]  frame_base,
   input  logic         af_full,
   output logic [30:0]  af_addr_din,
   output logic         af_wr_en,
   input  logic         rdf_valid,
   input  logic [127:0] rdf_dout,
   output logic         rdf_rd_en,
   output logic [23:0]  video,
   output logic         video_valid,
   input  logic         video_ready
`ifdef PIXEL_FEEDER_UNDERFLOW_COUNT_EN
   ,
   output logic [15:0]  underflow_count
`endif
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] LIMIT = (CW+1)'(BUF_DEPTH - 8);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_nx;
   logic [9:0]    x_req, y_req;
   logic [5:0]    base;
   logic [CW-1:0] occupancy, reserved;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [23:0]   mem [BUF_DEPTH];
   logic [CW:0]   level;
   logic          accept, push, pop, line_end, last_burst, latch_base;
   logic          unused_bits;

   assign unused_bits = ^{frame_base[31:28], frame_base[21:0], x_req[2:0],
                          rdf_dout[127:120], rdf_dout[95:88], rdf_dout[63:56], rdf_dout[31:24]};

   assign level       = {1'b0, occupancy} + {1'b0, reserved};
   assign line_end    = (x_req == 10'(H_PIXELS - 8));
   assign last_burst  = line_end && (y_req == 10'(V_PIXELS - 1));
   assign accept      = af_wr_en;
   assign push        = rdf_valid;
   assign rdf_rd_en   = rdf_valid;
   assign video_valid = (occupancy != '0);
   assign pop         = video_valid && video_ready;
   assign video       = video_valid ? mem[rd_ptr] : 24'h0;
   assign af_addr_din = {6'b0, base, y_req, x_req[9:3], 2'b0};

   always_comb begin
      state_nx   = state;
      af_wr_en   = 1'b0;
      latch_base = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               state_nx   = RUN;
               latch_base = 1'b1;
            end
         end
         RUN: begin
            // Space for both beats is reserved up front so the read-data pop never stalls.
            af_wr_en = !af_full && (level <= LIMIT);
            if (af_wr_en && last_burst) begin
               if (enable) latch_base = 1'b1;
               else        state_nx   = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         x_req     <= '0;
         y_req     <= '0;
         base      <= '0;
         occupancy <= '0;
         reserved  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
      end else begin
         state <= state_nx;
         if (latch_base) base <= frame_base[27:22];
         if (accept) begin
            if (line_end) begin
               x_req <= '0;
               y_req <= last_burst ? 10'd0 : y_req + 10'd1;
            end else begin
               x_req <= x_req + 10'd8;
            end
         end
         reserved  <= reserved + (accept ? CW'(8) : CW'(0)) - (push ? CW'(4) : CW'(0));
         occupancy <= occupancy + (push ? CW'(4) : CW'(0)) - (pop ? CW'(1) : CW'(0));
         if (push) wr_ptr <= wr_ptr + PW'(4);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Word 0 of a beat (bits 127:96) is the leftmost pixel; wr_ptr stays 4-aligned so no split wrap.
   always_ff @(posedge clk) begin
      if (push) begin
         for (int k = 0; k < 4; k++) begin
            mem[wr_ptr + PW'(k)] <= rdf_dout[96 - 32*k +: 24];
         end
      end
   end

`ifdef PIXEL_FEEDER_UNDERFLOW_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst || (state == IDLE && enable)) begin
         underflow_count <= '0;
      end else if (video_ready && !video_valid && underflow_count != 16'hFFFF) begin
         underflow_count <= underflow_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pixel_feeder.sv
// tb/tb_pixel_feeder.sv - directed table-driven bench for pixel_feeder (H=800, V=2, BUF=64)
module tb_pixel_feeder;

   localparam int H = 800;
   localparam int V = 2;
   localparam int B = 64;

   logic         clk;
   logic         rst;
   logic         enable;
   logic [31:0]  frame_base;
   logic         af_full;
   logic [30:0]  af_addr_din;
   logic         af_wr_en;
   logic         rdf_valid;
   logic [127:0] rdf_dout;
   logic         rdf_rd_en;
   logic [23:0]  video;
   logic         video_valid;
   logic         video_ready;
`ifdef PIXEL_FEEDER_UNDERFLOW_COUNT_EN
   logic [15:0]  underflow_count;
`endif

   pixel_feeder #(.H_PIXELS(H), .V_PIXELS(V), .BUF_DEPTH(B)) dut (
      .clk(clk), .rst(rst), .enable(enable), .frame_base(frame_base),
      .af_full(af_full), .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
      .rdf_valid(rdf_valid), .rdf_dout(rdf_dout), .rdf_rd_en(rdf_rd_en),
      .video(video), .video_valid(video_valid), .video_ready(video_ready)
`ifdef PIXEL_FEEDER_UNDERFLOW_COUNT_EN
      , .underflow_count(underflow_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] word;
      logic [23:0] exp;
   } pix_vec_t;

   int            n_pass = 0;
   int            n_total = 0;
   int            cyc = 0;
   int            rdy_mode = 0;
   bit            auto_mode = 0;
   bit            hold_data = 0;
   bit            chk_en = 0;
   logic [30:0]   acc_log[$];
   logic [30:0]   req_q[$];
   logic [127:0]  beat_q[$];
   logic [23:0]   exp_q[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [23:0] pix(input logic [5:0] b, input logic [9:0] y, input logic [9:0] x);
      return {b, y[7:0], x};
   endfunction

   function automatic logic [30:0] exp_addr(input logic [5:0] b, input logic [9:0] y, input logic [9:0] x);
      return {6'b0, b, y, x[9:3], 2'b0};
   endfunction

   function automatic logic [127:0] mk_beat(input logic [5:0] b, input logic [9:0] y, input logic [9:0] x0);
      logic [127:0] r;
      for (int k = 0; k < 4; k++) r[127 - 32*k -: 32] = {8'h5A, pix(b, y, x0 + 10'(k))};
      return r;
   endfunction

   // One cycle of stimulus: memory model delivers queued beats, display drives ready.
   task automatic tick();
      logic [30:0] a;
      @(negedge clk);
      cyc++;
      if (auto_mode) begin
         while (req_q.size() > 0) begin
            a = req_q.pop_front();
            beat_q.push_back(mk_beat(a[24:19], a[18:9], {a[8:2], 3'b0}));
            beat_q.push_back(mk_beat(a[24:19], a[18:9], {a[8:2], 3'b0} + 10'd4));
         end
      end
      if (!hold_data && beat_q.size() > 0) begin
         rdf_valid = 1'b1;
         rdf_dout  = beat_q.pop_front();
      end else begin
         rdf_valid = 1'b0;
         rdf_dout  = '0;
      end
      case (rdy_mode)
         1:       video_ready = 1'b1;
         2:       video_ready = (cyc % 7) != 3;
         default: video_ready = 1'b0;
      endcase
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (af_wr_en && !af_full) begin
            acc_log.push_back(af_addr_din);
            req_q.push_back(af_addr_din);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (chk_en && video_valid && video_ready) begin
            if (exp_q.size() == 0) chk("extra_pixel", {104'b0, video}, 128'hDEAD);
            else                   chk("pixel_stream", {104'b0, video}, {104'b0, exp_q.pop_front()});
         end
         if (!rst) chk("occ_plus_res_le_depth",
                       ((int'(dut.occupancy) + int'(dut.reserved)) <= B), 1);
      end
   end

   initial begin
      pix_vec_t     tbl[8];
      logic [127:0] beat0, beat1;
      int           n;
      bit           held;
      int           guard;

      tbl[0] = '{32'h00AABBCC, 24'hAABBCC};
      tbl[1] = '{32'h00000001, 24'h000001};
      tbl[2] = '{32'h00000002, 24'h000002};
      tbl[3] = '{32'h00000003, 24'h000003};
      tbl[4] = '{32'h00000004, 24'h000004};
      tbl[5] = '{32'h00000005, 24'h000005};
      tbl[6] = '{32'h00000006, 24'h000006};
      tbl[7] = '{32'hFF000007, 24'h000007};

      rst = 1'b1; enable = 1'b0; frame_base = '0; af_full = 1'b0;
      rdf_valid = 1'b0; rdf_dout = '0; video_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      #4;
      chk("reset_af_wr_en", af_wr_en, 0);
      chk("reset_rdf_rd_en", rdf_rd_en, 0);
      chk("reset_video_valid", video_valid, 0);
      chk("reset_video", video, 0);
      chk("reset_af_addr_din", af_addr_din, 0);

      // First fetch: exactly 8 bursts fill the reservation budget.
      tick();
      enable = 1'b1; frame_base = 32'h0040_0000;
      tick();
      enable = 1'b0;
      repeat (14) tick();
      #4;
      chk("initial_request_count", acc_log.size(), 8);
      for (int i = 0; i < 8 && i < acc_log.size(); i++)
         chk("initial_request_addr", acc_log[i], exp_addr(6'h01, 10'd0, 10'(8*i)));
      chk("stall_af_wr_en", af_wr_en, 0);

      // Hand-built beats for burst x=0 from the vector table.
      void'(req_q.pop_front());
      for (int k = 0; k < 4; k++) begin
         beat0[127 - 32*k -: 32] = tbl[k].word;
         beat1[127 - 32*k -: 32] = tbl[k+4].word;
      end
      beat_q.push_back(beat0);
      beat_q.push_back(beat1);
      tick();
      tick();
      #4;
      chk("first_pixel_latency_valid", video_valid, 1);
      chk("first_pixel_latency_data", video, 24'hAABBCC);
      tick();
      rdy_mode = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         #4;
         chk("table_video_valid", video_valid, 1);
         chk("table_video", video, tbl[i].exp);
      end
      tick();
      #4;
      chk("valid_drop_after_8", video_valid, 0);
      chk("empty_video_black", video, 0);
      rdy_mode = 0;

      // Rest of frame 1 from the memory model; enable is low so the FSM idles at frame end.
      for (int y = 0; y < V; y++)
         for (int x = (y == 0) ? 8 : 0; x < H; x++)
            exp_q.push_back(pix(6'h01, 10'(y), 10'(x)));
      chk_en = 1; auto_mode = 1; rdy_mode = 2;
      held = 0; guard = 0;
      while (exp_q.size() > 0 && guard < 6000) begin
         tick();
         guard++;
         if (!held && acc_log.size() == 40) begin
            held = 1;
            af_full = 1'b1;
            n = acc_log.size();
            for (int j = 0; j < 10; j++) begin
               #4;
               chk("af_full_blocks_wr_en", af_wr_en, 0);
               tick();
            end
            af_full = 1'b0;
            chk("af_full_no_advance", acc_log.size(), n);
         end
      end
      chk("frame1_drain_in_time", exp_q.size(), 0);
      chk("af_full_hold_exercised", held, 1);
      chk("frame1_request_count", acc_log.size(), 200);
      if (acc_log.size() >= 200) begin
         chk("line_wrap_last_x", acc_log[99], exp_addr(6'h01, 10'd0, 10'd792));
         chk("line_wrap_next_line", acc_log[100], exp_addr(6'h01, 10'd1, 10'd0));
         for (int i = 0; i < 200; i++)
            chk("frame1_addr_seq", acc_log[i], exp_addr(6'h01, 10'(i / 100), 10'(8 * (i % 100))));
      end
      repeat (5) tick();
      #4;
      chk("idle_after_frame_end", af_wr_en, 0);
      chk("idle_no_requests", acc_log.size(), 200);
      chk("drained_valid_low", video_valid, 0);

      // Re-enable on a new base with data withheld: 5 underflow cycles.
      chk_en = 0; hold_data = 1; rdy_mode = 1;
      tick();
      enable = 1'b1; frame_base = 32'h0080_0000;
      #4;
      chk("underflow_video", video, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 0) enable = 1'b0;
         #4;
         chk("underflow_video", video, 0);
         chk("underflow_valid", video_valid, 0);
      end
      rdy_mode = 0;
      tick();
      #4;
`ifdef PIXEL_FEEDER_UNDERFLOW_COUNT_EN
      chk("underflow_count", underflow_count, 5);
`endif
      chk("reenable_issued", acc_log.size() > 200, 1);
      if (acc_log.size() > 200)
         chk("reenable_first_addr", acc_log[200], exp_addr(6'h02, 10'd0, 10'd0));

      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++)
            exp_q.push_back(pix(6'h02, 10'(y), 10'(x)));
      chk_en = 1; hold_data = 0; rdy_mode = 2;
      guard = 0;
      while (exp_q.size() > 0 && guard < 6000) begin
         tick();
         guard++;
      end
      chk("frame2_drain_in_time", exp_q.size(), 0);
      repeat (3) tick();
      #4;
      chk("frame2_request_count", acc_log.size(), 400);
      chk("frame2_valid_low", video_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
